exu_sequencer: RTL and testbench

- Sequences the shared multicycle execution unit (integer MUL/MLA/UMULL/SMULL and FP FADD/FMUL) on behalf of the multicycle controller's main FSM.
- Accepts a one-cycle start request from the execute state, issues the op to the unit, and counts a fixed latency.
- Drives the writeback select and write enables (one or two register writes, or an FPU register write), then returns control via Done.
- Sits beside decode/condlogic inside the controller; stalls the main FSM while busy.

---
 rtl/exu_pkg.sv | 47 ++++
 rtl/exu_sequencer_if.sv | 32 +++
 rtl/exu_sequencer.sv | 103 ++++++++++
 tb/tb_exu_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// ============================================================================
// Module : exu_pkg
// Brief  : Shared encodings for the multicycle execution-unit sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package exu_pkg;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MLA   = 3'b001;
  localparam logic [2:0] OP_UMULL = 3'b010;
  localparam logic [2:0] OP_SMULL = 3'b011;
  localparam logic [2:0] OP_FADD  = 3'b100;
  localparam logic [2:0] OP_FMUL  = 3'b101;

  localparam logic [1:0] WBSEL_NONE = 2'b00;
  localparam logic [1:0] WBSEL_LO   = 2'b01;
  localparam logic [1:0] WBSEL_HI   = 2'b10;
  localparam logic [1:0] WBSEL_FP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB_LO = 3'd3,
    S_WB_HI = 3'd4,
    S_WB_FP = 3'd5,
    S_SKIP  = 3'd6
  } state_t;

  function automatic logic is_reserved(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

  function automatic logic is_fp(input logic [2:0] op);
    return op[2];
  endfunction

  // UMULL/SMULL produce a 64-bit result written over two cycles
  function automatic logic is_long(input logic [2:0] op);
    return (op[2] == 1'b0) && op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/exu_sequencer_if.sv
// ============================================================================
// Module : exu_sequencer_if
// Brief  : Handshake between the controller main FSM and the EXU sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface exu_sequencer_if;
  logic       Start;
  logic [2:0] Op;
  logic       CondEx;
  logic       UnitStart;
  logic [2:0] UnitOp;
  logic       Stall;
  logic [1:0] WbSel;
  logic       RegWriteX;
  logic       FPUWriteX;
  logic       Done;
  logic       Err;

  modport master (
    output Start, Op, CondEx,
    input  UnitStart, UnitOp, Stall, WbSel, RegWriteX, FPUWriteX, Done, Err
  );

  modport slave (
    input  Start, Op, CondEx,
    output UnitStart, UnitOp, Stall, WbSel, RegWriteX, FPUWriteX, Done, Err
  );
endinterface

`default_nettype wire

// File: rtl/exu_sequencer.sv
// ============================================================================
// Module : exu_sequencer
// Brief  : Issues an op to the shared multicycle EXU, times its latency and
//          drives writeback enables, stalling the main FSM while busy.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exu_sequencer
  import exu_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int FPU_LAT = 6,
  parameter int CNTW    = 4
) (
  input  wire logic    clk,
  input  wire logic    reset,
  exu_sequencer_if.slave bus
);

  if (MUL_LAT < 1 || FPU_LAT < 1) begin : g_lat_illegal
    $error("exu_sequencer: MUL_LAT and FPU_LAT must be >= 1");
  end

  if ((MUL_LAT >= (1 << CNTW)) || (FPU_LAT >= (1 << CNTW))) begin : g_cntw_small
    $error("exu_sequencer: CNTW too narrow for configured latency");
  end

  state_t            r_state;
  logic [CNTW-1:0]   r_cnt;
  logic [2:0]        r_unit_op;

  state_t            w_nxt;
  logic [2:0]        w_uop_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;

  always_comb begin
    w_nxt     = r_state;
    w_uop_nxt = r_unit_op;
    w_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          if (!bus.CondEx || is_reserved(bus.Op)) begin
            w_nxt     = S_SKIP;
            w_err_nxt = bus.CondEx && is_reserved(bus.Op);
          end else begin
            w_nxt     = S_ISSUE;
            w_uop_nxt = bus.Op;
          end
        end
      end
      S_ISSUE: w_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == CNTW'(1)) w_nxt = is_fp(r_unit_op) ? S_WB_FP : S_WB_LO;
      S_WB_LO: w_nxt = is_long(r_unit_op) ? S_WB_HI : S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    w_done_nxt = (w_nxt == S_WB_HI) || (w_nxt == S_WB_FP) || (w_nxt == S_SKIP) ||
                 ((w_nxt == S_WB_LO) && !is_long(w_uop_nxt));
  end

  // Outputs are computed from the next state so they are registered yet Moore
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_unit_op     <= OP_MUL;
      bus.UnitStart <= 1'b0;
      bus.Stall     <= 1'b0;
      bus.WbSel     <= WBSEL_NONE;
      bus.RegWriteX <= 1'b0;
      bus.FPUWriteX <= 1'b0;
      bus.Done      <= 1'b0;
      bus.Err       <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_unit_op <= w_uop_nxt;
      if (r_state == S_ISSUE) begin
        r_cnt <= is_fp(r_unit_op) ? CNTW'(FPU_LAT) : CNTW'(MUL_LAT);
      end else if (r_state == S_WAIT && r_cnt > CNTW'(1)) begin
        r_cnt <= r_cnt - CNTW'(1);
      end
      bus.UnitStart <= (w_nxt == S_ISSUE);
      bus.Stall     <= (w_nxt != S_IDLE) && !w_done_nxt;
      case (w_nxt)
        S_WB_LO: bus.WbSel <= WBSEL_LO;
        S_WB_HI: bus.WbSel <= WBSEL_HI;
        S_WB_FP: bus.WbSel <= WBSEL_FP;
        default: bus.WbSel <= WBSEL_NONE;
      endcase
      bus.RegWriteX <= (w_nxt == S_WB_LO) || (w_nxt == S_WB_HI);
      bus.FPUWriteX <= (w_nxt == S_WB_FP);
      bus.Done      <= w_done_nxt;
      bus.Err       <= w_err_nxt;
    end
  end

  assign bus.UnitOp = r_unit_op;

endmodule

`default_nettype wire

// File: tb/tb_exu_sequencer.sv
// ============================================================================
// Module : tb_exu_sequencer
// Brief  : Directed plus randomized bench for exu_sequencer against a
//          cycle-trace reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exu_sequencer;

  localparam int MUL_LAT = 4;
  localparam int FPU_LAT = 6;

  typedef struct {
    logic       us;
    logic [2:0] uop;
    logic       stall;
    logic [1:0] wbsel;
    logic       rw;
    logic       fw;
    logic       done;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;
  logic [2:0] last_op = 3'b000;
  exp_t q[$];

  exu_sequencer_if bus ();

  exu_sequencer #(.MUL_LAT(MUL_LAT), .FPU_LAT(FPU_LAT), .CNTW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".UnitStart"}, {3'b0, bus.UnitStart}, {3'b0, e.us});
    chk({tag, ".UnitOp"},    {1'b0, bus.UnitOp},    {1'b0, e.uop});
    chk({tag, ".Stall"},     {3'b0, bus.Stall},     {3'b0, e.stall});
    chk({tag, ".WbSel"},     {2'b0, bus.WbSel},     {2'b0, e.wbsel});
    chk({tag, ".RegWriteX"}, {3'b0, bus.RegWriteX}, {3'b0, e.rw});
    chk({tag, ".FPUWriteX"}, {3'b0, bus.FPUWriteX}, {3'b0, e.fw});
    chk({tag, ".Done"},      {3'b0, bus.Done},      {3'b0, e.done});
    chk({tag, ".Err"},       {3'b0, bus.Err},       {3'b0, e.err});
  endtask

  function automatic exp_t mk(input logic us, input logic [2:0] uop, input logic stall,
                              input logic [1:0] wbsel, input logic rw, input logic fw,
                              input logic done, input logic err);
    exp_t e;
    e.us = us; e.uop = uop; e.stall = stall; e.wbsel = wbsel;
    e.rw = rw; e.fw = fw; e.done = done; e.err = err;
    return e;
  endfunction

  // Expected per-cycle outputs from the cycle after Start through Done
  function automatic void build(input logic [2:0] op, input logic cex);
    bit reserved = (op == 3'b110) || (op == 3'b111);
    int lat;
    q.delete();
    if (!cex || reserved) begin
      q.push_back(mk(0, last_op, 0, 2'd0, 0, 0, 1, cex && reserved));
      return;
    end
    lat = (op >= 3'd4) ? FPU_LAT : MUL_LAT;
    q.push_back(mk(1, op, 1, 2'd0, 0, 0, 0, 0));
    for (int i = 0; i < lat; i++) q.push_back(mk(0, op, 1, 2'd0, 0, 0, 0, 0));
    if (op >= 3'd4) begin
      q.push_back(mk(0, op, 0, 2'd3, 0, 1, 1, 0));
    end else if (op >= 3'd2) begin
      q.push_back(mk(0, op, 1, 2'd1, 1, 0, 0, 0));
      q.push_back(mk(0, op, 0, 2'd2, 1, 0, 1, 0));
    end else begin
      q.push_back(mk(0, op, 0, 2'd1, 1, 0, 1, 0));
    end
    last_op = op;
  endfunction

  task automatic idle_cycle(input string tag);
    bus.Start = 1'b0;
    @(negedge clk);
    check_out(tag, mk(0, last_op, 0, 2'd0, 0, 0, 0, 0));
    @(posedge clk); #1;
  endtask

  // Start at cycle 0, then walk the expected trace; noise drives random
  // Start requests while busy, which must all be ignored
  task automatic run_op(input string tag, input logic [2:0] op, input logic cex, input bit noise);
    bus.Start = 1'b1; bus.Op = op; bus.CondEx = cex;
    @(negedge clk);
    check_out({tag, ".c0"}, mk(0, last_op, 0, 2'd0, 0, 0, 0, 0));
    @(posedge clk); #1;
    build(op, cex);
    foreach (q[i]) begin
      bus.Start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.Op     = 3'($urandom_range(0, 7));
      bus.CondEx = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_out($sformatf("%s.c%0d", tag, i + 1), q[i]);
      @(posedge clk); #1;
    end
    bus.Start = 1'b0;
  endtask

  initial begin
    bus.Start = 1'b0; bus.Op = 3'b000; bus.CondEx = 1'b0;
    #1;
    check_out("reset", mk(0, 3'b000, 0, 2'd0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_cycle("idle0");

    run_op("mul",   3'b000, 1'b1, 1'b0);
    run_op("umull", 3'b010, 1'b1, 1'b0);
    run_op("fadd",  3'b100, 1'b1, 1'b0);
    run_op("nocond", 3'b000, 1'b0, 1'b0);
    run_op("rsvd",  3'b110, 1'b1, 1'b0);
    run_op("mla",   3'b001, 1'b1, 1'b1);
    run_op("fmul_b2b", 3'b101, 1'b1, 1'b0);
    idle_cycle("idle1");

    // Asynchronous reset in the middle of a MUL
    bus.Start = 1'b1; bus.Op = 3'b000; bus.CondEx = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_out("async_rst", mk(0, 3'b000, 0, 2'd0, 0, 0, 0, 0));
    last_op = 3'b000;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) idle_cycle($sformatf("post_rst%0d", i));
    run_op("mul_after_rst", 3'b000, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      logic       cex;
      op  = 3'($urandom_range(0, 7));
      cex = ($urandom_range(0, 7) != 0);
      run_op($sformatf("rnd%0d", n), op, cex, 1'b1);
      if ($urandom_range(0, 2) == 0) idle_cycle($sformatf("rnd_idle%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
